// File: rtl/mem_target.sv
// rtl/mem_target.sv - CPU bus responder: 256-byte RAM plus status/input/output I/O window (option: MEM_TARGET_PROTECT_EN)
module mem_target #(
  parameter logic [7:0] IO_BASE     = 8'hFD,
  parameter logic [7:0] PROTECT_TOP = 8'h40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic       rden,
  input  logic       wren,
  output logic [7:0] data_out,
  input  logic [7:0] io_in,
  input  logic       io_in_valid,
  output logic       io_in_ready,
  output logic [7:0] io_out,
  output logic       io_out_valid,
  input  logic       io_out_ready
);

  localparam logic [7:0] STAT_ADDR = IO_BASE;
  localparam logic [7:0] IN_ADDR   = IO_BASE + 8'd1;
  localparam logic [7:0] OUT_ADDR  = IO_BASE + 8'd2;

  logic [7:0] mem_q [256];

  logic [7:0] data_out_q, data_out_d;
  logic [7:0] in_data_q;
  logic       in_full_q;
  logic [7:0] out_data_q;
  logic       out_valid_q;
  logic       ovf_q;
  logic       prot_q;

  logic wr_en, rd_en;
  logic hit_ram, hit_stat, hit_in, hit_out;
  logic out_hs, out_accept, ram_we, prot_hit;

  // Address decode; a write wins when both request lines are high
  always_comb begin
    wr_en      = wren;
    rd_en      = rden & ~wren;
    hit_ram    = (addr < IO_BASE);
    hit_stat   = (addr == STAT_ADDR);
    hit_in     = (addr == IN_ADDR);
    hit_out    = (addr == OUT_ADDR);
    out_hs     = out_valid_q & io_out_ready;
    out_accept = wr_en & hit_out & (~out_valid_q | out_hs);
  end

`ifdef MEM_TARGET_PROTECT_EN
  assign prot_hit = wr_en & hit_ram & (addr < PROTECT_TOP);

  // Sticky protect-violation flag, cleared by any status write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prot_q <= 1'b0;
    end else if (wr_en && hit_stat) begin
      prot_q <= 1'b0;
    end else if (prot_hit) begin
      prot_q <= 1'b1;
    end
  end
`else
  logic [7:0] unused_protect_top;
  assign unused_protect_top = PROTECT_TOP;
  assign prot_hit           = 1'b0;
  assign prot_q             = 1'b0;
`endif

  assign ram_we = wr_en & hit_ram & ~prot_hit;

  // RAM array is deliberately not reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[addr] <= data_in;
    end
  end

  // Read data mux; non-read cycles hold the previous data_out
  always_comb begin
    data_out_d = data_out_q;
    if (rd_en) begin
      if (hit_ram) begin
        data_out_d = mem_q[addr];
      end else if (hit_stat) begin
        data_out_d = {4'b0000, prot_q, ovf_q, out_valid_q, in_full_q};
      end else if (hit_in) begin
        data_out_d = in_full_q ? in_data_q : 8'h00;
      end else if (hit_out) begin
        data_out_d = out_data_q;
      end else begin
        data_out_d = 8'h00;
      end
    end
  end

  // Registered read data, input latch, output port and overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q  <= 8'h00;
      in_data_q   <= 8'h00;
      in_full_q   <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      data_out_q <= data_out_d;

      // Full latch only empties on a read; empty latch loads on valid
      if (in_full_q) begin
        if (rd_en && hit_in) begin
          in_full_q <= 1'b0;
        end
      end else if (io_in_valid) begin
        in_full_q <= 1'b1;
        in_data_q <= io_in;
      end

      // A write during the handshake cycle refills the port
      if (out_accept) begin
        out_data_q  <= data_in;
        out_valid_q <= 1'b1;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end

      if (wr_en && hit_stat) begin
        ovf_q <= 1'b0;
      end else if (wr_en && hit_out && !out_accept) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign data_out     = data_out_q;
  assign io_in_ready  = ~in_full_q;
  assign io_out       = out_data_q;
  assign io_out_valid = out_valid_q;

endmodule

// File: tb/tb_mem_target.sv
// tb/tb_mem_target.sv - directed self-checking bench for mem_target
module tb_mem_target;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic       rden = 1'b0;
  logic       wren = 1'b0;
  logic [7:0] data_out;
  logic [7:0] io_in = 8'h00;
  logic       io_in_valid = 1'b0;
  logic       io_in_ready;
  logic [7:0] io_out;
  logic       io_out_valid;
  logic       io_out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_target dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .data_in      (data_in),
    .rden         (rden),
    .wren         (wren),
    .data_out     (data_out),
    .io_in        (io_in),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_out       (io_out),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready)
  );

  // One bus cycle: drive at negedge, let one posedge pass, sample #1 later
  task automatic bus(input logic [7:0] a, input logic [7:0] d, input logic r, input logic w);
    @(negedge clk);
    addr = a; data_in = d; rden = r; wren = w;
    @(posedge clk);
    #1;
    rden = 1'b0; wren = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out actual=%h required=00", data_out); end
    checks++;
    if (io_out !== 8'h00) begin failures++; $display("FAIL reset_io_out actual=%h required=00", io_out); end
    checks++;
    if (io_out_valid !== 1'b0) begin failures++; $display("FAIL reset_io_out_valid actual=%b required=0", io_out_valid); end
    checks++;
    if (io_in_ready !== 1'b1) begin failures++; $display("FAIL reset_io_in_ready actual=%b required=1", io_in_ready); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ram();
    bus(8'h10, 8'h5A, 1'b0, 1'b1);
    bus(8'h10, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h5A) begin failures++; $display("FAIL ram_read_10 actual=%h required=5a", data_out); end
    bus(8'h11, 8'hA7, 1'b0, 1'b1);
    bus(8'h10, 8'h00, 1'b1, 1'b0);
    bus(8'h11, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'hA7) begin failures++; $display("FAIL ram_read_11 actual=%h required=a7", data_out); end
    idle_cycle();
    checks++;
    if (data_out !== 8'hA7) begin failures++; $display("FAIL ram_idle_hold actual=%h required=a7", data_out); end
  endtask

  task automatic test_rw_priority();
    bus(8'h10, 8'h00, 1'b1, 1'b0);
    bus(8'h20, 8'h33, 1'b1, 1'b1);
    checks++;
    if (data_out !== 8'h5A) begin failures++; $display("FAIL rw_prio_data_out actual=%h required=5a", data_out); end
    bus(8'h20, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h33) begin failures++; $display("FAIL rw_prio_mem20 actual=%h required=33", data_out); end
  endtask

  task automatic test_input();
    @(negedge clk);
    io_in = 8'hC3; io_in_valid = 1'b1;
    @(posedge clk);
    #1;
    io_in_valid = 1'b0;
    checks++;
    if (io_in_ready !== 1'b0) begin failures++; $display("FAIL in_ready_after_load actual=%b required=0", io_in_ready); end
    bus(8'hFD, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h01) begin failures++; $display("FAIL in_status_full actual=%h required=01", data_out); end
    bus(8'hFE, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'hC3) begin failures++; $display("FAIL in_read_byte actual=%h required=c3", data_out); end
    checks++;
    if (io_in_ready !== 1'b1) begin failures++; $display("FAIL in_ready_after_read actual=%b required=1", io_in_ready); end
    bus(8'hFE, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h00) begin failures++; $display("FAIL in_read_empty actual=%h required=00", data_out); end
    bus(8'hFD, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h00) begin failures++; $display("FAIL in_status_empty actual=%h required=00", data_out); end
    // Read and offer in the same cycle: old byte returned, new byte refused
    @(negedge clk);
    io_in = 8'h77; io_in_valid = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    io_in = 8'h88; addr = 8'hFE; rden = 1'b1;
    @(posedge clk);
    #1;
    rden = 1'b0; io_in_valid = 1'b0;
    checks++;
    if (data_out !== 8'h77) begin failures++; $display("FAIL in_read_old_byte actual=%h required=77", data_out); end
    checks++;
    if (io_in_ready !== 1'b1) begin failures++; $display("FAIL in_new_refused actual=%b required=1", io_in_ready); end
  endtask

  task automatic test_output();
    io_out_ready = 1'b0;
    bus(8'hFF, 8'h11, 1'b0, 1'b1);
    checks++;
    if (io_out !== 8'h11 || io_out_valid !== 1'b1) begin failures++; $display("FAIL out_first_write actual=%h/%b required=11/1", io_out, io_out_valid); end
    bus(8'hFF, 8'h22, 1'b0, 1'b1);
    checks++;
    if (io_out !== 8'h11) begin failures++; $display("FAIL out_drop actual=%h required=11", io_out); end
    bus(8'hFD, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h06) begin failures++; $display("FAIL out_status_ovf actual=%h required=06", data_out); end
    bus(8'hFF, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h11) begin failures++; $display("FAIL out_readback actual=%h required=11", data_out); end
    @(negedge clk);
    io_out_ready = 1'b1;
    @(posedge clk);
    #1;
    io_out_ready = 1'b0;
    checks++;
    if (io_out_valid !== 1'b0 || io_out !== 8'h11) begin failures++; $display("FAIL out_handshake actual=%b/%h required=0/11", io_out_valid, io_out); end
    bus(8'hFD, 8'h00, 1'b0, 1'b1);
    bus(8'hFD, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h00) begin failures++; $display("FAIL out_status_clear actual=%h required=00", data_out); end
    // Write on the handshake cycle is accepted
    bus(8'hFF, 8'h44, 1'b0, 1'b1);
    @(negedge clk);
    io_out_ready = 1'b1; addr = 8'hFF; data_in = 8'h55; wren = 1'b1;
    @(posedge clk);
    #1;
    wren = 1'b0; io_out_ready = 1'b0;
    checks++;
    if (io_out !== 8'h55 || io_out_valid !== 1'b1) begin failures++; $display("FAIL out_hs_write actual=%h/%b required=55/1", io_out, io_out_valid); end
    bus(8'hFD, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h02) begin failures++; $display("FAIL out_hs_status actual=%h required=02", data_out); end
  endtask

  task automatic test_protect();
    bus(8'h05, 8'hFF, 1'b0, 1'b1);
    bus(8'h05, 8'h00, 1'b1, 1'b0);
`ifdef MEM_TARGET_PROTECT_EN
    checks++;
    if (data_out === 8'hFF) begin failures++; $display("FAIL prot_mem05 actual=%h required=not ff", data_out); end
    bus(8'hFD, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out[3] !== 1'b1) begin failures++; $display("FAIL prot_bit3 actual=%b required=1", data_out[3]); end
`else
    checks++;
    if (data_out !== 8'hFF) begin failures++; $display("FAIL prot_mem05 actual=%h required=ff", data_out); end
    bus(8'hFD, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out[3] !== 1'b0) begin failures++; $display("FAIL prot_bit3 actual=%b required=0", data_out[3]); end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    io_in = 8'h9E; io_in_valid = 1'b1;
    @(posedge clk);
    #1;
    io_in_valid = 1'b0;
    bus(8'hFD, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h03) begin failures++; $display("FAIL mid_status_before actual=%h required=03", data_out); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00 || io_out !== 8'h00 || io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_async_reset actual=%h/%h/%b/%b required=00/00/0/1", data_out, io_out, io_out_valid, io_in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    bus(8'h10, 8'h00, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h5A) begin failures++; $display("FAIL mid_ram_kept actual=%h required=5a", data_out); end
  endtask

  initial begin
    #12;
    test_reset();
    test_ram();
    test_rw_priority();
    test_input();
    test_output();
    test_protect();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
